// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// Optional MADD (op=7) is compiled in when the MDU_MADD_EN macro is defined.
module mdu_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam int unsigned DW         = 2 * WIDTH;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
`ifdef MDU_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd7;
`endif

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic             is_mul_c;
  logic             is_div_c;
  logic             accept_c;

  logic             mul_signed_c;
  logic [DW-1:0]    ext_a_c;
  logic [DW-1:0]    ext_b_c;
  logic [DW-1:0]    prod_c;
`ifdef MDU_MADD_EN
  logic [DW-1:0]    acc_c;
`endif

  logic             div_signed_c;
  logic             a_neg_c;
  logic             b_neg_c;
  logic [WIDTH-1:0] mag_a_c;
  logic [WIDTH-1:0] mag_b_c;
  logic [WIDTH-1:0] safe_b_c;
  logic [WIDTH-1:0] quo_c;
  logic [WIDTH-1:0] rem_c;
  logic [WIDTH-1:0] div_q_c;
  logic [WIDTH-1:0] div_r_c;

  logic             res_wr_c;
  logic [WIDTH-1:0] res_hi_c;
  logic [WIDTH-1:0] res_lo_c;

  // Decode of an arithmetic start request
  always_comb begin
    is_mul_c = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_MADD_EN
    is_mul_c = is_mul_c || (op == OP_MADD);
`endif
    is_div_c = (op == OP_DIV) || (op == OP_DIVU);
    accept_c = start && (state == S_IDLE) && (is_mul_c || is_div_c);
  end

  // Product: sign- or zero-extend to 2*WIDTH so one unsigned multiply serves both
  always_comb begin
    mul_signed_c = (op_q != OP_MULTU);
    ext_a_c = mul_signed_c ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    ext_b_c = mul_signed_c ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod_c  = ext_a_c * ext_b_c;
`ifdef MDU_MADD_EN
    acc_c   = {hi, lo} + prod_c;
`endif
  end

  // Signed divide on magnitudes; most-negative / -1 falls out as most-negative, rem 0
  always_comb begin
    div_signed_c = (op_q == OP_DIV);
    a_neg_c      = div_signed_c && a_q[WIDTH-1];
    b_neg_c      = div_signed_c && b_q[WIDTH-1];
    mag_a_c      = a_neg_c ? -a_q : a_q;
    mag_b_c      = b_neg_c ? -b_q : b_q;
    safe_b_c     = (b_q == '0) ? WIDTH'(1) : mag_b_c;
    quo_c        = mag_a_c / safe_b_c;
    rem_c        = mag_a_c % safe_b_c;
    div_q_c      = (a_neg_c ^ b_neg_c) ? -quo_c : quo_c;
    div_r_c      = a_neg_c ? -rem_c : rem_c;
  end

  // Completion result select; divide by zero leaves HI/LO untouched
  always_comb begin
    res_wr_c             = 1'b1;
    {res_hi_c, res_lo_c} = prod_c;
    case (op_q)
      OP_DIV, OP_DIVU: begin
        res_wr_c = (b_q != '0);
        res_hi_c = div_r_c;
        res_lo_c = div_q_c;
      end
`ifdef MDU_MADD_EN
      OP_MADD: {res_hi_c, res_lo_c} = acc_c;
`endif
      default: ;
    endcase
  end

  // FSM, countdown and HI/LO registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
      op_q  <= OP_NOP;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept_c) begin
            state <= S_RUN;
            busy  <= 1'b1;
            cnt   <= is_div_c ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            op_q  <= op;
            a_q   <= rs_val;
            b_q   <= rt_val;
          end else if (op == OP_MTHI) begin
            hi <= rs_val;
          end else if (op == OP_MTLO) begin
            lo <= rs_val;
          end
        end
        S_RUN: begin
          if (cnt == CNT_W'(1)) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            if (res_wr_c) begin
              hi <= res_hi_c;
              lo <= res_lo_c;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: vector table plus hand-written corner sequences.
module tb_mdu_unit;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_MADD  = 3'd7;
  localparam int NVEC = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = OP_NOP;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          cyc;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  vec_t vecs [NVEC];
  exp_t sb [$];
  int   checks = 0;
  int   failures = 0;

  mdu_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
  endtask

  task automatic mt(input logic [2:0] o, input logic [31:0] v);
    @(negedge clk);
    op = o; rs_val = v;
    @(negedge clk);
    op = OP_NOP;
  endtask

  task automatic push_exp(input logic [31:0] h, input logic [31:0] l, input int c);
    exp_t e;
    e.hi = h; e.lo = l; e.cyc = c;
    sb.push_back(e);
  endtask

  // Count busy cycles starting at the negedge just after the accepting edge
  task automatic wait_done(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic pop_check(input string name, input int n);
    exp_t e;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s scoreboard empty actual=%0d required=1", name, sb.size());
    end else begin
      e = sb.pop_front();
      check({name, "_cycles"}, 64'(n), 64'(e.cyc));
      check({name, "_hi"}, 64'(hi), 64'(e.hi));
      check({name, "_lo"}, 64'(lo), 64'(e.lo));
    end
  endtask

  initial begin
    int n;
    vecs[0] = '{OP_MULT,  32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 5};
    vecs[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{OP_DIVU,  32'd7,        32'd2,        32'h00000001, 32'h00000003, 10};
    vecs[4] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[5] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[6] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
    vecs[7] = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 5};
    vecs[8] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 10};
    vecs[9] = '{OP_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 5};

    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    rst_n = 1'b1;

    // Table-driven arithmetic vectors
    for (int i = 0; i < NVEC; i++) begin
      push_exp(vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].cyc);
      issue(vecs[i].op, vecs[i].rs, vecs[i].rt);
      wait_done(n);
      pop_check($sformatf("vec%0d", i), n);
    end

    // NOP start must not raise busy
    issue(OP_NOP, 32'd1, 32'd1);
    check("nop_start_busy", 64'(busy), 64'd0);

    // MTHI / MTLO while idle
    mt(OP_MTHI, 32'h00001234);
    check("mthi", 64'(hi), 64'h1234);
    mt(OP_MTHI, 32'h00000011);
    mt(OP_MTLO, 32'h00000022);
    check("mtlo", 64'(lo), 64'h22);

    // DIVU by zero with MTLO/MTHI attempted while busy: HI/LO unchanged
    push_exp(32'h11, 32'h22, 10);
    issue(OP_DIVU, 32'd7, 32'd0);
    n = 0;
    while (busy && n < 200) begin
      n++;
      if (n == 2) begin
        op = OP_MTLO; rs_val = 32'hDEADBEEF;
      end else if (n == 3) begin
        op = OP_MTHI; rs_val = 32'hCAFEF00D;
      end else begin
        op = OP_NOP;
      end
      @(negedge clk);
    end
    op = OP_NOP;
    pop_check("div0_mt_busy", n);

    // Second start while busy must not restart or extend
    push_exp(32'h0, 32'hF, 5);
    issue(OP_MULT, 32'd3, 32'd5);
    n = 0;
    while (busy && n < 200) begin
      n++;
      if (n == 2) begin
        start = 1'b1; op = OP_DIV; rs_val = 32'd100; rt_val = 32'd3;
      end else begin
        start = 1'b0; op = OP_NOP;
      end
      @(negedge clk);
    end
    start = 1'b0; op = OP_NOP;
    pop_check("restart_ignored", n);

    // Asynchronous reset in cycle 3 of a DIV
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
    repeat (2) @(negedge clk);
    check("pre_reset_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midop_reset_busy", 64'(busy), 64'd0);
    check("midop_reset_hi", 64'(hi), 64'd0);
    check("midop_reset_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(32'hFFFFFFFF, 32'hFFFFFFFE, 5);
    issue(OP_MULT, 32'hFFFFFFFF, 32'd2);
    wait_done(n);
    pop_check("post_reset_mult", n);

    // MADD: accumulate when enabled, ignored otherwise
    mt(OP_MTHI, 32'h0);
    mt(OP_MTLO, 32'hFFFFFFFF);
`ifdef MDU_MADD_EN
    push_exp(32'h1, 32'h0, 5);
    issue(OP_MADD, 32'd1, 32'd1);
    wait_done(n);
    pop_check("madd", n);
`else
    issue(OP_MADD, 32'd1, 32'd1);
    check("madd_off_busy", 64'(busy), 64'd0);
    repeat (6) @(negedge clk);
    check("madd_off_hi", 64'(hi), 64'h0);
    check("madd_off_lo", 64'(lo), 64'hFFFFFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
